// File: rtl/if_prefetch_unit.sv
// Instruction-fetch stage: a single-outstanding request port to instruction memory,
// a FIFO_DEPTH-entry prefetch buffer towards decode, and EX redirect/flush handling.
module if_prefetch_unit #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic            redirect_jalr,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            cs_i_n,
  output logic [XLEN-1:0] i_addr,
  input  logic            i_ready,
  input  logic            i_rvalid,
  input  logic [XLEN-1:0] instr_read,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instrCode,
  output logic [XLEN-1:0] PC_IF,
  output logic [XLEN-1:0] PC_4_IF,
  output logic            fetch_misaligned
);
  localparam int            PW   = $clog2(FIFO_DEPTH);
  localparam int            CW   = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  logic [XLEN-1:0] fpc_q, req_pc_q;
  logic            outstanding_q, drop_q, halt_q, misaligned_q;
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q;
  logic [XLEN-1:0] fifo_pc_q    [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_instr_q [FIFO_DEPTH];

  logic [XLEN-1:0] target;
  logic            req_en, accept, resp, push, pop;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    target = redirect_pc;
    if (redirect_jalr) target[0] = 1'b0;
  end

  assign req_en = rst & ~outstanding_q & ~halt_q & ~redirect_valid & (count_q < FULL);
  assign accept = req_en & i_ready;
  assign resp   = i_rvalid & outstanding_q;
  assign push   = resp & ~drop_q & ~redirect_valid;
  assign pop    = instr_valid & instr_ready;

  assign cs_i_n           = ~req_en;
  assign i_addr           = fpc_q;
  assign instr_valid      = (count_q != '0);
  assign instrCode        = instr_valid ? fifo_instr_q[rd_ptr_q] : '0;
  assign PC_IF            = instr_valid ? fifo_pc_q[rd_ptr_q] : '0;
  assign PC_4_IF          = instr_valid ? fifo_pc_q[rd_ptr_q] + XLEN'(4) : '0;
  assign fetch_misaligned = misaligned_q;

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    if (!rst) begin
      fpc_q         <= RESET_PC;
      req_pc_q      <= '0;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
      halt_q        <= 1'b0;
      misaligned_q  <= 1'b0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      misaligned_q <= redirect_valid & target[1];
      if (resp) begin
        outstanding_q <= 1'b0;
      end else if (accept) begin
        outstanding_q <= 1'b1;
        req_pc_q      <= fpc_q;
        fpc_q         <= fpc_q + XLEN'(4);
      end
      if (redirect_valid) begin
        // A response still in flight belongs to the old path and must be thrown away.
        fpc_q    <= target;
        halt_q   <= target[1];
        drop_q   <= outstanding_q & ~i_rvalid;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (resp) drop_q <= 1'b0;
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        case ({push, pop})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: ;
        endcase
      end
    end
  end

  // NOTE: the buffer storage is not reset; emptiness is tracked by count_q and outputs mask to zero.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]    <= req_pc_q;
      fifo_instr_q[wr_ptr_q] <= instr_read;
    end
  end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Self-checking bench for if_prefetch_unit: a latency-configurable memory responder
// and a scoreboard queue of expected {pc, instr} entries compared at the FIFO head.
module tb_if_prefetch_unit;
  localparam int          XLEN  = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid, redirect_jalr;
  logic [31:0] redirect_pc;
  logic        cs_i_n;
  logic [31:0] i_addr;
  logic        i_ready, i_rvalid;
  logic [31:0] instr_read;
  logic        instr_valid, instr_ready;
  logic [31:0] instrCode, PC_IF, PC_4_IF;
  logic        fetch_misaligned;

  always #5 clk = ~clk;

  if_prefetch_unit #(.XLEN(XLEN), .RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_jalr(redirect_jalr), .redirect_pc(redirect_pc),
    .cs_i_n(cs_i_n), .i_addr(i_addr), .i_ready(i_ready), .i_rvalid(i_rvalid),
    .instr_read(instr_read), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instrCode(instrCode), .PC_IF(PC_IF), .PC_4_IF(PC_4_IF), .fetch_misaligned(fetch_misaligned)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } entry_t;

  entry_t      sb[$];
  int          checks = 0;
  int          errors = 0;
  bit          pend, kill, halted, exp_mis, spurious;
  logic [31:0] pend_addr, exp_fpc;
  int          pend_wait, lat, dut_accepts;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    pend = 0; kill = 0; halted = 0; exp_mis = 0; spurious = 0;
    pend_addr = '0; exp_fpc = RPC; pend_wait = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs_i_n"}, cs_i_n, 1);
    check({tag, "_i_addr"}, i_addr, RPC);
    check({tag, "_valid"}, instr_valid, 0);
    check({tag, "_instr"}, instrCode, 0);
    check({tag, "_pc"}, PC_IF, 0);
    check({tag, "_pc4"}, PC_4_IF, 0);
    check({tag, "_mis"}, fetch_misaligned, 0);
  endtask

  // One clock cycle: called just after a falling edge with the cycle's inputs already set.
  task automatic cycle();
    bit          exp_req, resp;
    entry_t      e;
    logic [31:0] t;
    i_rvalid   = spurious || (pend && pend_wait == 0);
    instr_read = i_rvalid ? mem_word(pend_addr) : $urandom;
    #1;
    exp_req = !pend && !halted && !redirect_valid && (sb.size() < DEPTH);
    check("cs_i_n", cs_i_n, !exp_req);
    if (exp_req) check("i_addr", i_addr, exp_fpc);
    if (!cs_i_n && i_ready) dut_accepts++;
    check("misaligned", fetch_misaligned, exp_mis);
    check("instr_valid", instr_valid, sb.size() != 0);
    if (sb.size() != 0) begin
      e = sb[0];
      check("instrCode", instrCode, e.ins);
      check("PC_IF", PC_IF, e.pc);
      check("PC_4_IF", PC_4_IF, e.pc + 32'd4);
      if (instr_ready) void'(sb.pop_front());
    end else begin
      check("empty_instr", instrCode, 0);
      check("empty_pc", PC_IF, 0);
    end
    resp = i_rvalid && pend;
    @(posedge clk);
    if (pend && pend_wait > 0) pend_wait--;
    if (redirect_valid) begin
      t = redirect_pc;
      if (redirect_jalr) t[0] = 1'b0;
      sb.delete();
      exp_fpc = t;
      halted  = t[1];
      exp_mis = t[1];
      kill    = pend && !resp;
    end else begin
      exp_mis = 0;
      if (resp) begin
        if (!kill) begin
          e.pc  = pend_addr;
          e.ins = mem_word(pend_addr);
          sb.push_back(e);
        end
        kill = 0;
      end
    end
    if (resp) pend = 0;
    if (exp_req && i_ready) begin
      pend      = 1;
      pend_addr = exp_fpc;
      pend_wait = lat - 1;
      exp_fpc   = exp_fpc + 32'd4;
    end
    @(negedge clk);
    spurious = 0;
  endtask

  task automatic redirect(input logic [31:0] pc, input bit jalr);
    redirect_valid = 1; redirect_pc = pc; redirect_jalr = jalr;
    cycle();
    redirect_valid = 0; redirect_jalr = 0;
  endtask

  // Stop new requests, let any response land, then restart cleanly at pc.
  task automatic settle_at(input logic [31:0] pc);
    i_ready = 0; instr_ready = 1;
    repeat (6) cycle();
    redirect(pc, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    redirect_valid = 0; redirect_jalr = 0; redirect_pc = '0;
    i_ready = 0; i_rvalid = 0; instr_read = '0; instr_ready = 0;
    lat = 1; dut_accepts = 0;
    model_reset();
    rst = 1;
    #1 rst = 0;
    #2 check_reset_outputs("por");
    @(negedge clk); @(negedge clk);
    rst = 1;

    // Streaming at 1-cycle latency.
    i_ready = 1; instr_ready = 1; lat = 1;
    repeat (20) cycle();

    // Back-pressure: exactly DEPTH requests, then drain in PC order.
    settle_at(32'h0);
    dut_accepts = 0; instr_ready = 0; i_ready = 1;
    repeat (25) cycle();
    check("fill_requests", dut_accepts, DEPTH);
    instr_ready = 1;
    repeat (20) cycle();

    // Redirect while the request to 0x8 is outstanding.
    settle_at(32'h0);
    lat = 3; i_ready = 1; instr_ready = 1;
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (pend && pend_addr == 32'h8 && pend_wait > 0) found = 1;
      else cycle();
    end
    check("reach_req_8", found, 1);
    redirect(32'h100, 0);
    repeat (20) cycle();

    // jalr bit0 clearing, misaligned halt and recovery.
    lat = 1;
    redirect(32'h205, 1);
    repeat (10) cycle();
    redirect(32'h206, 0);
    repeat (10) cycle();
    redirect(32'h300, 0);
    repeat (10) cycle();

    // Redirect coinciding with a response and a pop.
    settle_at(32'h380);
    lat = 3; i_ready = 1; instr_ready = 0;
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (sb.size() != 0 && pend && pend_wait == 0) found = 1;
      else cycle();
    end
    check("reach_coincide", found, 1);
    instr_ready = 1;
    redirect(32'h400, 0);
    repeat (15) cycle();

    // Random traffic with occasional redirects.
    for (int i = 0; i < 300; i++) begin
      i_ready     = ($urandom_range(0, 3) != 0);
      instr_ready = ($urandom_range(0, 2) != 0);
      lat         = $urandom_range(1, 3);
      if ($urandom_range(0, 19) == 0) begin
        redirect_pc = ($urandom & 32'h0000_0FFC) |
                      (($urandom_range(0, 4) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
        redirect_valid = 1; redirect_jalr = $urandom_range(0, 1);
      end
      cycle();
      redirect_valid = 0; redirect_jalr = 0;
    end

    // Reset mid-fetch with a request outstanding, then a stale response.
    settle_at(32'h500);
    lat = 3; i_ready = 1; instr_ready = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (pend && pend_wait > 0) found = 1;
      else cycle();
    end
    check("reach_pending", found, 1);
    #2 rst = 0;
    #1 check_reset_outputs("mid");
    i_rvalid = 1; instr_read = 32'hDEAD_BEEF;
    @(posedge clk); @(posedge clk);
    #1 check_reset_outputs("held");
    @(negedge clk);
    model_reset();
    rst = 1; instr_ready = 1; lat = 1;
    spurious = 1;
    cycle();
    repeat (15) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
